// File: rtl/multicycle_memory_pkg.sv
// Shared definitions for multicycle_memory: FSM state encoding and
// operation codes carried on the `op` port.
package multicycle_memory_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_NOP2  = 2'b10;
    localparam logic [1:0] OP_NOP3  = 2'b11;

endpackage

// File: rtl/mm_ram.sv
// Synchronous single-port storage array for multicycle_memory.
// Ports:
//   clk   - rising-edge clock
//   we    - write enable; stores wdata at addr on the rising edge
//   addr  - word address
//   wdata - write data
//   rdata - registered read of mem[addr] (read-before-write on the same edge)
module mm_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset on purpose; resetting it would turn a
    // plain RAM into 2^ADDR_W flops. Contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/multicycle_memory.sv
// Byte-wide memory behind a start/done handshake with fixed latency.
// A request is latched in IDLE, passes through SETUP and ACCESS_CYCLES
// cycles of ACCESS, commits on the last ACCESS edge and pulses `done`.
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset (memory array is not reset)
//   start      - request strobe, only honoured in IDLE
//   op         - 00 write, 01 read, 10/11 no-op
//   addr       - target address, latched with start
//   write_data - write data, latched with start
//   done       - one-cycle completion pulse (registered)
//   read_data  - result of the most recent read, held until the next read
module multicycle_memory
    import multicycle_memory_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    output logic              done,
    output logic [DATA_W-1:0] read_data
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    state_t            state;
    state_t            state_next;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              commit;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign commit = (state == ACCESS) && (cnt == '0);
    assign ram_we = commit && (op_q == OP_WRITE);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default before the case so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (start) state_next = SETUP;
            SETUP:  state_next = ACCESS;
            ACCESS: if (cnt == '0) state_next = DONE;
            DONE:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            read_data <= '0;
        end else begin
            // done is high exactly while the FSM sits in DONE.
            done <= commit;

            if (state == IDLE && start) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= write_data;
            end

            if (state == SETUP) begin
                cnt <= CNT_W'(ACCESS_CYCLES - 1);
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            // The RAM reads addr_q every cycle; addr_q is stable from the
            // SETUP edge on, so ram_rdata is valid by the commit edge even
            // with a single ACCESS cycle.
            if (commit && op_q == OP_READ) begin
                read_data <= ram_rdata;
            end
        end
    end

    mm_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_multicycle_memory.sv
// Self-checking bench for multicycle_memory: directed scenarios followed by
// randomized transactions compared against a behavioural memory model.
module tb_multicycle_memory;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int AC     = 2;

    logic              clk;
    logic              rst;
    logic              start;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              done;
    logic [DATA_W-1:0] read_data;

    multicycle_memory #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .ACCESS_CYCLES(AC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .addr       (addr),
        .write_data (write_data),
        .done       (done),
        .read_data  (read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: contents and whether each entry has been written.
    logic [DATA_W-1:0] mem_m   [2**ADDR_W];
    bit                known_m [2**ADDR_W];
    logic [DATA_W-1:0] exp_rd;
    bit                exp_rd_known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic check_rd(input string tag);
        if (exp_rd_known) check(tag, 32'(read_data), 32'(exp_rd));
    endtask

    // One full transaction: start sampled at the next edge, `done` expected
    // exactly AC+1 edges later, then one cycle low again. Inputs are
    // scrambled after sampling; with noise=1 start is also pulsed while busy.
    task automatic txn(input logic [1:0] o, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input bit noise);
        logic [DATA_W-1:0] new_rd;
        bit                new_known;
        start      = 1'b1;
        op         = o;
        addr       = a;
        write_data = d;
        @(posedge clk);
        #1;
        new_rd    = exp_rd;
        new_known = exp_rd_known;
        if (o == 2'b01) begin
            new_rd    = mem_m[a];
            new_known = known_m[a];
        end
        start      = noise;
        op         = 2'($urandom);
        addr       = ADDR_W'($urandom);
        write_data = DATA_W'($urandom);
        for (int k = 1; k <= AC + 1; k++) begin
            @(posedge clk);
            #1;
            if (k == AC + 1) begin
                exp_rd       = new_rd;
                exp_rd_known = new_known;
            end
            check("done_timing", 32'(done), 32'(k == AC + 1));
            check_rd("read_data");
        end
        // Commit happened on the last edge above; update the model's array.
        if (o == 2'b00) begin
            mem_m[a]   = d;
            known_m[a] = 1'b1;
        end
        @(posedge clk);
        #1;
        check("done_low", 32'(done), 32'd0);
        check_rd("read_data_hold");
        start = 1'b0;
    endtask

    initial begin
        start        = 1'b0;
        op           = 2'b00;
        addr         = '0;
        write_data   = '0;
        exp_rd       = '0;
        exp_rd_known = 1'b1;
        for (int i = 0; i < 2**ADDR_W; i++) known_m[i] = 1'b0;

        // Reset state.
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_read_data", 32'(read_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("idle_done", 32'(done), 32'd0);
        end

        // Write then read.
        txn(2'b00, 8'd10, 8'd42, 1'b0);
        txn(2'b01, 8'd10, 8'd0, 1'b0);
        check("rd10", 32'(read_data), 32'd42);

        // Start pulses while busy are ignored.
        txn(2'b00, 8'd5, 8'hAA, 1'b1);
        txn(2'b01, 8'd5, 8'h00, 1'b0);
        check("rd5", 32'(read_data), 32'hAA);

        // Latched inputs; top address.
        txn(2'b00, 8'd20, 8'd7, 1'b0);
        txn(2'b00, 8'd255, 8'hFF, 1'b0);
        txn(2'b01, 8'd20, 8'd0, 1'b0);
        check("rd20", 32'(read_data), 32'd7);
        txn(2'b01, 8'd255, 8'd0, 1'b0);
        check("rd255", 32'(read_data), 32'hFF);

        // No-ops leave read_data and memory alone.
        txn(2'b10, 8'd10, 8'd99, 1'b0);
        txn(2'b11, 8'd10, 8'd98, 1'b0);
        check("nop_hold", 32'(read_data), 32'hFF);
        txn(2'b01, 8'd10, 8'd0, 1'b0);
        check("nop_mem", 32'(read_data), 32'd42);

        // Reset during SETUP aborts a write.
        txn(2'b00, 8'd3, 8'd1, 1'b0);
        start      = 1'b1;
        op         = 2'b00;
        addr       = 8'd3;
        write_data = 8'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        #1;
        check("abort_done", 32'(done), 32'd0);
        check("abort_read_data", 32'(read_data), 32'd0);
        exp_rd       = '0;
        exp_rd_known = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < AC + 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", 32'(done), 32'd0);
        end
        txn(2'b01, 8'd3, 8'd0, 1'b0);
        check("abort_mem", 32'(read_data), 32'd1);

        // Randomized traffic over a small address window to get reuse.
        for (int i = 0; i < 300; i++) begin
            txn(2'($urandom), ADDR_W'($urandom_range(0, 15)),
                DATA_W'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
